// File: rtl/fpu_pkg.sv
// Shared FPU definitions: float field layout, one-hot status codes, converter states.
// Float layout is {sign, exp[5:0] biased by EXP_BIAS, mant[24:0] with hidden 1}.
package fpu_pkg;

  localparam int EXP_W    = 6;
  localparam int MANT_W   = 25;
  localparam int EXP_BIAS = 31;
  localparam int SIG_W    = MANT_W + 1;
  localparam int INT_W    = 32;

  localparam logic [3:0] ST_EXACT     = 4'b0001;
  localparam logic [3:0] ST_INEXACT   = 4'b0010;
  localparam logic [3:0] ST_OVERFLOW  = 4'b0100;
  localparam logic [3:0] ST_UNDERFLOW = 4'b1000;

  localparam logic [INT_W-1:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [INT_W-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_SHIFT  = 3'd2,
    S_PACK   = 3'd3,
    S_DONE   = 3'd4
  } fp2i_state_t;

  typedef enum logic [2:0] {
    FC_ZERO  = 3'd0,
    FC_SMALL = 3'd1,
    FC_RIGHT = 3'd2,
    FC_LEFT  = 3'd3,
    FC_BIG   = 3'd4
  } fp_class_t;

  function automatic logic [INT_W-1:0] sat_value(input logic sign);
    return sign ? INT_MIN : INT_MAX;
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational split of an FPU float into sign/significand and a shift plan
// (class, shift amount, direction) for alignment onto an integer binary point.
module fp_unpack
  import fpu_pkg::*;
(
  input  logic [INT_W-1:0] fp_i,
  output logic             sign_o,
  output logic [SIG_W-1:0] sig_o,
  output fp_class_t        cls_o,
  output logic [4:0]       shamt_o,
  output logic             shift_left_o,
  output logic             min_neg_o
);

  localparam logic signed [6:0] E_MIN_R = -7'sd1;
  localparam logic signed [6:0] E_MAX_R = 7'sd25;
  localparam logic signed [6:0] E_MAX_L = 7'sd30;
  localparam logic signed [6:0] E_INT_MIN = 7'sd31;

  logic [EXP_W-1:0]  exp_s;
  logic [MANT_W-1:0] mant_s;
  logic signed [6:0] e_s;

  assign sign_o    = fp_i[INT_W-1];
  assign exp_s     = fp_i[INT_W-2 -: EXP_W];
  assign mant_s    = fp_i[MANT_W-1:0];
  assign sig_o     = {1'b1, mant_s};
  assign e_s       = signed'({1'b0, exp_s} - 7'(EXP_BIAS));
  // -2^31 is the only E>=31 value that still fits the integer range
  assign min_neg_o = sign_o && (e_s == E_INT_MIN) && (mant_s == '0);

  // Classify the unbiased exponent; shift amounts use 5-bit wraparound arithmetic.
  always_comb begin
    cls_o        = FC_ZERO;
    shamt_o      = 5'd0;
    shift_left_o = 1'b0;
    if ((exp_s == '0) && (mant_s == '0)) begin
      cls_o = FC_ZERO;
    end else if (e_s < E_MIN_R) begin
      cls_o = FC_SMALL;
    end else if (e_s <= E_MAX_R) begin
      cls_o   = FC_RIGHT;
      shamt_o = 5'd25 - e_s[4:0];
    end else if (e_s <= E_MAX_L) begin
      cls_o        = FC_LEFT;
      shamt_o      = e_s[4:0] - 5'd25;
      shift_left_o = 1'b1;
    end else begin
      cls_o = FC_BIG;
    end
  end

endmodule

// File: rtl/fp_to_int.sv
// Sequential float-to-int32 converter, one shift per clock, start/busy/done handshake.
// Build option: define FP2INT_ROUND_NEAREST_EN for round-to-nearest-even (default truncates).
module fp_to_int
  import fpu_pkg::*;
(
  input  logic             clock100KHz,
  input  logic             reset,
  input  logic             start,
  input  logic [INT_W-1:0] fp_in,
  output logic [INT_W-1:0] int_out,
  output logic [3:0]       status_out,
  output logic             busy,
  output logic             done
);

  fp2i_state_t      state_q;
  logic [INT_W-1:0] fp_q;
  logic [INT_W-1:0] acc_q;
  logic [INT_W-1:0] int_out_q;
  logic [3:0]       status_q;
  logic [4:0]       cnt_q;
  logic             guard_q;
  logic             sticky_q;
  logic             busy_q;
  logic             done_q;

  logic [INT_W-1:0] mag_d;
  logic [INT_W-1:0] res_d;
  logic [3:0]       status_d;

  logic             sign_s;
  logic [SIG_W-1:0] sig_s;
  fp_class_t        cls_s;
  logic [4:0]       shamt_s;
  logic             shift_left_s;
  logic             min_neg_s;

  // fp_q is stable from UNPACK through DONE, so the plan stays valid for PACK too
  fp_unpack u_unpack (
    .fp_i         (fp_q),
    .sign_o       (sign_s),
    .sig_o        (sig_s),
    .cls_o        (cls_s),
    .shamt_o      (shamt_s),
    .shift_left_o (shift_left_s),
    .min_neg_o    (min_neg_s)
  );

  // Final magnitude, sign application and status priority for the PACK state.
  always_comb begin
    mag_d = acc_q;
`ifdef FP2INT_ROUND_NEAREST_EN
    if (guard_q && (sticky_q || acc_q[0])) begin
      mag_d = acc_q + 32'd1;
    end else begin
      mag_d = acc_q;
    end
`endif
    res_d    = '0;
    status_d = ST_EXACT;
    case (cls_s)
      FC_ZERO: begin
        res_d    = '0;
        status_d = ST_EXACT;
      end
      FC_BIG: begin
        if (min_neg_s) begin
          res_d    = INT_MIN;
          status_d = ST_EXACT;
        end else begin
          res_d    = sat_value(sign_s);
          status_d = ST_OVERFLOW;
        end
      end
      FC_SMALL, FC_RIGHT, FC_LEFT: begin
        if (!sign_s && mag_d[INT_W-1]) begin
          res_d    = INT_MAX;
          status_d = ST_OVERFLOW;
        end else if (mag_d == '0) begin
          res_d    = '0;
          status_d = ST_UNDERFLOW;
        end else begin
          res_d    = sign_s ? (32'd0 - mag_d) : mag_d;
          status_d = (guard_q || sticky_q) ? ST_INEXACT : ST_EXACT;
        end
      end
      default: begin
        res_d    = '0;
        status_d = ST_EXACT;
      end
    endcase
  end

  // Conversion FSM with registered handshake and result outputs.
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      fp_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= 5'd0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
      int_out_q <= '0;
      status_q  <= ST_EXACT;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            fp_q    <= fp_in;
            busy_q  <= 1'b1;
            state_q <= S_UNPACK;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_UNPACK: begin
          guard_q <= 1'b0;
          cnt_q   <= shamt_s;
          case (cls_s)
            FC_RIGHT, FC_LEFT: begin
              acc_q    <= {{(INT_W-SIG_W){1'b0}}, sig_s};
              sticky_q <= 1'b0;
            end
            FC_SMALL: begin
              acc_q    <= '0;
              sticky_q <= 1'b1;
            end
            default: begin
              acc_q    <= '0;
              sticky_q <= 1'b0;
            end
          endcase
          state_q <= (shamt_s == 5'd0) ? S_PACK : S_SHIFT;
        end
        S_SHIFT: begin
          if (shift_left_s) begin
            acc_q <= {acc_q[INT_W-2:0], 1'b0};
          end else begin
            acc_q    <= {1'b0, acc_q[INT_W-1:1]};
            guard_q  <= acc_q[0];
            sticky_q <= sticky_q | guard_q;
          end
          cnt_q   <= cnt_q - 5'd1;
          state_q <= (cnt_q <= 5'd1) ? S_PACK : S_SHIFT;
        end
        S_PACK: begin
          int_out_q <= res_d;
          status_q  <= status_d;
          done_q    <= 1'b1;
          state_q   <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign int_out    = int_out_q;
  assign status_out = status_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_fp_to_int.sv
// Scoreboard bench for fp_to_int: driver queues hand-computed results, a negedge
// monitor pops and compares result, status and latency on every done pulse.
module tb_fp_to_int;

  localparam logic [3:0] EX = 4'b0001;
  localparam logic [3:0] IN = 4'b0010;
  localparam logic [3:0] OV = 4'b0100;
  localparam logic [3:0] UN = 4'b1000;

  logic        clock100KHz = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] fp_in = 32'd0;
  logic [31:0] int_out;
  logic [3:0]  status_out;
  logic        busy;
  logic        done;

  typedef struct {
    logic [31:0] fp;
    logic [31:0] res;
    logic [3:0]  st;
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   n_pushed = 0;
  logic done_prev = 1'b0;

  fp_to_int dut (
    .clock100KHz (clock100KHz),
    .reset       (reset),
    .start       (start),
    .fp_in       (fp_in),
    .int_out     (int_out),
    .status_out  (status_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock100KHz = ~clock100KHz;

  always @(posedge clock100KHz) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Pick the expectation matching the build's rounding mode.
  task automatic push_exp(input logic [31:0] fp, input logic [31:0] rt, input logic [3:0] st_t,
                          input logic [31:0] rr, input logic [3:0] st_r, input int lat);
    exp_t e;
    e.fp = fp;
`ifdef FP2INT_ROUND_NEAREST_EN
    e.res = rr;
    e.st  = st_r;
`else
    e.res = rt;
    e.st  = st_t;
`endif
    e.lat       = lat;
    e.start_cyc = cyc;
    sb_q.push_back(e);
    n_pushed++;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && (n < budget)) begin
      @(negedge clock100KHz);
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Called at a negedge; returns at the first negedge back in IDLE.
  task automatic convert(input logic [31:0] fp, input logic [31:0] rt, input logic [3:0] st_t,
                         input logic [31:0] rr, input logic [3:0] st_r, input int lat);
    start = 1'b1;
    fp_in = fp;
    @(posedge clock100KHz);
    #1;
    push_exp(fp, rt, st_t, rr, st_r, lat);
    @(negedge clock100KHz);
    start = 1'b0;
    fp_in = ~fp;
    wait_idle(60);
  endtask

  // Monitor: every done pulse is matched against the oldest queued expectation.
  always @(negedge clock100KHz) begin
    exp_t e;
    if (done) begin
      done_cnt++;
      chk("done_one_cycle", {31'd0, done_prev}, 32'd0);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 with int_out=0x%08h, expected no done", int_out);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("int_out[%08h]", e.fp), int_out, e.res);
        chk($sformatf("status[%08h]", e.fp), {28'd0, status_out}, {28'd0, e.st});
        chk($sformatf("latency[%08h]", e.fp), 32'(cyc - e.start_cyc + 1), 32'(e.lat));
      end
    end
    done_prev = done;
  end

  initial begin
    int dc0;
    repeat (3) @(negedge clock100KHz);
    chk("rst_int_out", int_out, 32'd0);
    chk("rst_status", {28'd0, status_out}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b1;
    @(negedge clock100KHz);

    //       fp_in          trunc result   st   round result   st   latency
    convert(32'h3E00_0000, 32'h0000_0001, EX, 32'h0000_0001, EX, 28);
    convert(32'h3F00_0000, 32'h0000_0001, IN, 32'h0000_0002, IN, 28);
    convert(32'h4080_0000, 32'h0000_0002, IN, 32'h0000_0002, IN, 27);
    convert(32'hC080_0000, 32'hFFFF_FFFE, IN, 32'hFFFF_FFFE, IN, 27);
    convert(32'h41C0_0000, 32'h0000_0003, IN, 32'h0000_0004, IN, 27);
    convert(32'hFC00_0000, 32'h8000_0000, EX, 32'h8000_0000, EX, 3);
    convert(32'h7C00_0000, 32'h7FFF_FFFF, OV, 32'h7FFF_FFFF, OV, 3);
    convert(32'hFC00_0001, 32'h8000_0000, OV, 32'h8000_0000, OV, 3);
    convert(32'h0000_0000, 32'h0000_0000, EX, 32'h0000_0000, EX, 3);
    convert(32'h3A00_0000, 32'h0000_0000, UN, 32'h0000_0000, UN, 3);
    convert(32'h3C00_0000, 32'h0000_0000, UN, 32'h0000_0000, UN, 29);
    convert(32'h3D00_0000, 32'h0000_0000, UN, 32'h0000_0001, IN, 29);
    convert(32'h7000_0001, 32'h0200_0001, EX, 32'h0200_0001, EX, 3);
    convert(32'h7200_0000, 32'h0400_0000, EX, 32'h0400_0000, EX, 4);
    convert(32'h7A00_0000, 32'h4000_0000, EX, 32'h4000_0000, EX, 8);
    convert(32'hFBFF_FFFF, 32'h8000_0020, EX, 32'h8000_0020, EX, 8);
    convert(32'hBE00_0000, 32'hFFFF_FFFF, EX, 32'hFFFF_FFFF, EX, 28);

    // start held high with fp_in changing every cycle: exactly one conversion of 1.0
    dc0 = done_cnt;
    start = 1'b1;
    fp_in = 32'h3E00_0000;
    @(posedge clock100KHz);
    #1;
    push_exp(32'h3E00_0000, 32'd1, EX, 32'd1, EX, 28);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock100KHz);
      fp_in = fp_in ^ 32'h5A5A_5A5A;
      if (done) start = 1'b0;
    end
    start = 1'b0;
    chk("hold_single_done", 32'(done_cnt - dc0), 32'd1);

    // asynchronous reset in the middle of SHIFT
    dc0 = done_cnt;
    start = 1'b1;
    fp_in = 32'h3E00_0000;
    @(negedge clock100KHz);
    start = 1'b0;
    repeat (10) @(negedge clock100KHz);
    reset = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_int_out", int_out, 32'd0);
    chk("midrst_status", {28'd0, status_out}, 32'd1);
    @(negedge clock100KHz);
    reset = 1'b1;
    repeat (35) @(negedge clock100KHz);
    chk("midrst_no_done", 32'(done_cnt - dc0), 32'd0);
    convert(32'h3F00_0000, 32'h0000_0001, IN, 32'h0000_0002, IN, 28);

    repeat (5) @(negedge clock100KHz);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    chk("done_total", 32'(done_cnt), 32'(n_pushed));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
